// File: rtl/sliced_seq_alu.sv
// Multi-cycle WIDTH-bit ALU: one SLICE-bit slice per clock, LSB first, with a registered carry.
// Uses a start/busy/done handshake; result and flags change only on the final slice edge.
module sliced_seq_alu #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_bx;
    logic [31:0]      w_shamt;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_res_sl;
    logic             w_c_out;
    logic             w_c_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_final;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = start ? S_RUN : S_IDLE;
            S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    // Slice datapath: the carry into a slice's top bit is recovered from sum ^ a ^ b.
    always_comb begin
        w_bx     = r_op[2] ? ~r_b : r_b;
        w_shamt  = 32'(r_cnt) * 32'(SLICE);
        w_a_sl   = SLICE'(r_a >> w_shamt);
        w_b_sl   = SLICE'(w_bx >> w_shamt);
        w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE + 1)'(r_carry);
        w_c_out  = w_sum[SLICE];
        w_c_msb  = w_sum[SLICE-1] ^ w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1];
        w_ovf    = w_c_msb ^ w_c_out;
        case (r_op[1:0])
            2'b00:   w_res_sl = w_a_sl & w_b_sl;
            2'b01:   w_res_sl = w_a_sl | w_b_sl;
            default: w_res_sl = w_sum[SLICE-1:0];
        endcase
        w_mask     = WIDTH'({SLICE{1'b1}}) << w_shamt;
        w_acc_next = (r_acc & ~w_mask) | (WIDTH'(w_res_sl) << w_shamt);
        w_final    = w_acc_next;
        if (r_op[1:0] == 2'b11) begin
            w_final = WIDTH'(w_sum[SLICE-1] ^ w_ovf);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= op[2];
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_carry <= w_c_out;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_result   <= w_final;
                r_cout     <= w_c_out;
                r_overflow <= w_ovf;
                r_zero     <= (w_final == '0);
            end
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_overflow;
    assign zero     = r_zero;

endmodule
